oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 105 ++++++++++
 tb/tb_oam_dma.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to TRIGGER_ADDR takes over the bus and copies
// one 256-byte page of system memory into the PPU OAM data port, one
// READ/WRITE pair per byte, after a HALT cycle and an optional ALIGN cycle.
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    input  logic        odd_or_even,
    input  logic [7:0]  mem_din,
    output logic        dma_hijack,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_dout,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_data;
    logic        r_done;
    logic        w_trigger;

    // Only a CPU write to the trigger address while idle starts a transfer.
    assign w_trigger = (r_state == S_IDLE) && (bus_addr == TRIGGER_ADDR) && !bus_wr;

    // State, page/index/data latches and the completion pulse.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_page  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_WRITE) && (r_idx == 8'hFF);
            if (w_trigger) begin
                r_page <= bus_din;
                r_idx  <= '0;
            end
            if (r_state == S_READ) begin
                r_data <= mem_din;
            end
            if (r_state == S_WRITE) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    // Next-state logic and output decode from registered state only.
    always_comb begin
        w_next     = r_state;
        dma_hijack = 1'b1;
        dma_addr   = 16'h0000;
        dma_rw     = 1'b1;
        dma_dout   = 8'h00;
        dma_done   = r_done;
        unique case (r_state)
            S_IDLE: begin
                dma_hijack = 1'b0;
                if (w_trigger) w_next = S_HALT;
            end
            S_HALT: begin
                // The trigger address is the only address that can start a
                // transfer, so the held trigger address is the parameter.
                dma_addr = TRIGGER_ADDR;
                w_next   = odd_or_even ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
                dma_addr = TRIGGER_ADDR;
                w_next   = S_READ;
            end
            S_READ: begin
                dma_addr = {r_page, r_idx};
                w_next   = S_WRITE;
            end
            S_WRITE: begin
                dma_addr = OAM_DATA_ADDR;
                dma_rw   = 1'b0;
                dma_dout = r_data;
                w_next   = (r_idx == 8'hFF) ? S_IDLE : S_READ;
            end
            default: begin
                dma_hijack = 1'b0;
                w_next     = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed testbench for oam_dma: a memory model feeds mem_din, each
// transfer is recorded cycle by cycle and compared against expected bus
// activity computed from the page number and start parity.
`timescale 1ns/1ps
module tb_oam_dma;

    logic        cpu_clk;
    logic        reset;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        bus_wr;
    logic        odd_or_even;
    logic [7:0]  mem_din;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_dout;
    logic        dma_done;

    int total = 0;
    int bad   = 0;

    // Recorded transfer
    logic [15:0] obs_addr [0:599];
    logic        obs_rw   [0:599];
    logic [7:0]  obs_dout [0:599];
    int          obs_len;
    logic        obs_end_hijack;
    logic [15:0] obs_end_addr;
    logic        obs_done0;
    logic        obs_done1;
    logic        obs_hijack1;

    oam_dma #(
        .TRIGGER_ADDR  (16'h4014),
        .OAM_DATA_ADDR (16'h2004)
    ) dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .bus_addr    (bus_addr),
        .bus_din     (bus_din),
        .bus_wr      (bus_wr),
        .odd_or_even (odd_or_even),
        .mem_din     (mem_din),
        .dma_hijack  (dma_hijack),
        .dma_addr    (dma_addr),
        .dma_rw      (dma_rw),
        .dma_dout    (dma_dout),
        .dma_done    (dma_done)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return (a[7:0] ^ 8'h5A) + a[15:8];
    endfunction

    // System memory model: returns data for whatever address is driven.
    always_comb mem_din = mem_byte(dma_addr);

    // Expected bus tuple {addr, rw, dout} for hijack cycle n of a transfer.
    function automatic logic [24:0] exp_cycle(input logic [7:0] page, input bit odd, input int n);
        int k;
        logic [7:0] idx;
        if (n == 0 || (odd && n == 1)) return {16'h4014, 1'b1, 8'h00};
        k   = n - 1 - (odd ? 1 : 0);
        idx = 8'(k / 2);
        if (k % 2 == 0) return {page, idx, 1'b1, 8'h00};
        return {16'h2004, 1'b0, mem_byte({page, idx})};
    endfunction

    task automatic release_bus();
        bus_addr = 16'h0000;
        bus_wr   = 1'b1;
        bus_din  = 8'h00;
    endtask

    // Drives one transfer and records the hijack window; no checking here.
    task automatic run_dma(input logic [7:0] page, input bit odd, input bit skip_trig,
                           input int retrig_at, input int abort_at,
                           input bit chain, input logic [7:0] chain_page);
        int n;
        if (!skip_trig) begin
            @(negedge cpu_clk);
            bus_addr = 16'h4014; bus_wr = 1'b0; bus_din = page;
            @(negedge cpu_clk);
        end
        release_bus();
        odd_or_even = odd;
        n = 0;
        while (n < 600 && dma_hijack) begin
            obs_addr[n] = dma_addr;
            obs_rw[n]   = dma_rw;
            obs_dout[n] = dma_dout;
            if (n == retrig_at) begin
                bus_addr = 16'h4014; bus_wr = 1'b0; bus_din = 8'h07;
            end
            if (n == abort_at) reset = 1'b1;
            n++;
            @(negedge cpu_clk);
            reset = 1'b0;
            release_bus();
            odd_or_even = ~odd_or_even;
        end
        obs_len        = n;
        obs_end_hijack = dma_hijack;
        obs_end_addr   = dma_addr;
        obs_done0      = dma_done;
        if (chain) begin
            bus_addr = 16'h4014; bus_wr = 1'b0; bus_din = chain_page;
        end
        @(negedge cpu_clk);
        release_bus();
        obs_done1   = dma_done;
        obs_hijack1 = dma_hijack;
    endtask

    task automatic test_reset();
        @(negedge cpu_clk);
        reset = 1'b1;
        bus_addr = 16'h4014; bus_wr = 1'b0; bus_din = 8'h09;
        @(negedge cpu_clk);
        total++;
        if ({dma_hijack, dma_addr, dma_rw, dma_dout, dma_done} !== {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h",
                     {dma_hijack, dma_addr, dma_rw, dma_dout, dma_done}, {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
        end
        release_bus();
        @(negedge cpu_clk);
        reset = 1'b0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        total++;
        if (dma_hijack !== 1'b0) begin
            bad++;
            $display("FAIL reset_priority hijack got=%b want=0", dma_hijack);
        end
    endtask

    task automatic test_non_trigger();
        @(negedge cpu_clk);
        bus_addr = 16'h4014; bus_wr = 1'b1; bus_din = 8'h02;
        @(negedge cpu_clk);
        total++;
        if (dma_hijack !== 1'b0) begin
            bad++;
            $display("FAIL read_4014 hijack got=%b want=0", dma_hijack);
        end
        bus_addr = 16'h4015; bus_wr = 1'b0;
        @(negedge cpu_clk);
        release_bus();
        total++;
        if (dma_hijack !== 1'b0 || dma_addr !== 16'h0000) begin
            bad++;
            $display("FAIL write_4015 hijack/addr got=%b/%h want=0/0000", dma_hijack, dma_addr);
        end
    endtask

    task automatic test_even_start();
        run_dma(8'h02, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00);
        total++;
        if (obs_len !== 513) begin
            bad++;
            $display("FAIL even_len got=%0d want=513", obs_len);
        end
        for (int n = 0; n < obs_len && n < 513; n++) begin
            total++;
            if ({obs_addr[n], obs_rw[n], obs_dout[n]} !== exp_cycle(8'h02, 1'b0, n)) begin
                bad++;
                $display("FAIL even_cycle%0d got=%h want=%h", n,
                         {obs_addr[n], obs_rw[n], obs_dout[n]}, exp_cycle(8'h02, 1'b0, n));
            end
        end
        total++;
        if ({obs_end_addr, obs_done0, obs_done1} !== {16'h0000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL even_done addr/done/done_next got=%h/%b/%b want=0000/1/0",
                     obs_end_addr, obs_done0, obs_done1);
        end
    endtask

    task automatic test_odd_start();
        run_dma(8'h02, 1'b1, 1'b0, -1, -1, 1'b0, 8'h00);
        total++;
        if (obs_len !== 514) begin
            bad++;
            $display("FAIL odd_len got=%0d want=514", obs_len);
        end
        for (int n = 0; n < obs_len && n < 514; n++) begin
            total++;
            if ({obs_addr[n], obs_rw[n], obs_dout[n]} !== exp_cycle(8'h02, 1'b1, n)) begin
                bad++;
                $display("FAIL odd_cycle%0d got=%h want=%h", n,
                         {obs_addr[n], obs_rw[n], obs_dout[n]}, exp_cycle(8'h02, 1'b1, n));
            end
        end
        total++;
        if ({obs_done0, obs_done1} !== 2'b10) begin
            bad++;
            $display("FAIL odd_done got=%b want=10", {obs_done0, obs_done1});
        end
    endtask

    task automatic test_retrigger();
        run_dma(8'h03, 1'b0, 1'b0, 50, -1, 1'b0, 8'h00);
        total++;
        if (obs_len !== 513) begin
            bad++;
            $display("FAIL retrig_len got=%0d want=513", obs_len);
        end
        for (int n = 0; n < obs_len && n < 513; n++) begin
            total++;
            if ({obs_addr[n], obs_rw[n], obs_dout[n]} !== exp_cycle(8'h03, 1'b0, n)) begin
                bad++;
                $display("FAIL retrig_cycle%0d got=%h want=%h", n,
                         {obs_addr[n], obs_rw[n], obs_dout[n]}, exp_cycle(8'h03, 1'b0, n));
            end
        end
        total++;
        if ({obs_done0, obs_hijack1} !== 2'b10) begin
            bad++;
            $display("FAIL retrig_no_restart done/hijack_next got=%b want=10", {obs_done0, obs_hijack1});
        end
    endtask

    task automatic test_reset_abort();
        run_dma(8'h04, 1'b0, 1'b0, -1, 99, 1'b0, 8'h00);
        total++;
        if (obs_len !== 100) begin
            bad++;
            $display("FAIL abort_len got=%0d want=100", obs_len);
        end
        total++;
        if ({obs_end_hijack, obs_end_addr, obs_done0, obs_done1, obs_hijack1} !== {1'b0, 16'h0000, 3'b000}) begin
            bad++;
            $display("FAIL abort_state got=%h want=%h",
                     {obs_end_hijack, obs_end_addr, obs_done0, obs_done1, obs_hijack1}, {1'b0, 16'h0000, 3'b000});
        end
        run_dma(8'h04, 1'b1, 1'b0, -1, -1, 1'b0, 8'h00);
        total++;
        if (obs_len !== 514) begin
            bad++;
            $display("FAIL abort_rerun_len got=%0d want=514", obs_len);
        end
        for (int n = 0; n < obs_len && n < 514; n++) begin
            total++;
            if ({obs_addr[n], obs_rw[n], obs_dout[n]} !== exp_cycle(8'h04, 1'b1, n)) begin
                bad++;
                $display("FAIL abort_rerun_cycle%0d got=%h want=%h", n,
                         {obs_addr[n], obs_rw[n], obs_dout[n]}, exp_cycle(8'h04, 1'b1, n));
            end
        end
    endtask

    task automatic test_back_to_back();
        run_dma(8'h01, 1'b0, 1'b0, -1, -1, 1'b1, 8'h05);
        total++;
        if ({obs_len == 513, obs_done0, obs_done1, obs_hijack1} !== 4'b1101) begin
            bad++;
            $display("FAIL b2b_first len_ok/done/done_next/hijack_next got=%b want=1101",
                     {obs_len == 513, obs_done0, obs_done1, obs_hijack1});
        end
        run_dma(8'h05, 1'b0, 1'b1, -1, -1, 1'b0, 8'h00);
        total++;
        if (obs_addr[1] !== 16'h0500) begin
            bad++;
            $display("FAIL b2b_first_read got=%h want=0500", obs_addr[1]);
        end
        total++;
        if (obs_len !== 513) begin
            bad++;
            $display("FAIL b2b_second_len got=%0d want=513", obs_len);
        end
        for (int n = 0; n < obs_len && n < 513; n++) begin
            total++;
            if ({obs_addr[n], obs_rw[n], obs_dout[n]} !== exp_cycle(8'h05, 1'b0, n)) begin
                bad++;
                $display("FAIL b2b_cycle%0d got=%h want=%h", n,
                         {obs_addr[n], obs_rw[n], obs_dout[n]}, exp_cycle(8'h05, 1'b0, n));
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        odd_or_even = 1'b0;
        release_bus();
        test_reset();
        test_non_trigger();
        test_even_start();
        test_odd_start();
        test_retrigger();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
